// File: rtl/mist_frame_trig.sv
// Frame trigger for the waveform-dump controller: counts VGA_VS falling edges
// after a ROM download, opens a dump window and raises a sticky finish request.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   VGA_VS      vertical sync, sampled on clk
//   downloading ROM download in progress; holds the block idle
//   frame_cnt   frames completed since the last download ended
//   vs_fall     one-cycle pulse per VGA_VS falling edge
//   dump_en     dump window active
//   finish_req  sticky request to end the simulation
//   trig_st     0 IDLE, 1 ARMED, 2 DUMPING, 3 DONE
module mist_frame_trig #(
    parameter int unsigned START_FRAME  = 0,
    parameter int unsigned DUMP_FRAMES  = 0,
    parameter int unsigned FINISH_FRAME = 0,
    parameter int unsigned CNTW         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            VGA_VS,
    input  logic            downloading,
    output logic [CNTW-1:0] frame_cnt,
    output logic            vs_fall,
    output logic            dump_en,
    output logic            finish_req,
    output logic [1:0]      trig_st
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DUMPING = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [CNTW-1:0] START_C  = CNTW'(START_FRAME);
    localparam logic [CNTW-1:0] DUMP_C   = CNTW'(DUMP_FRAMES);
    localparam logic [CNTW-1:0] FINISH_C = CNTW'(FINISH_FRAME);

    state_e          state_q, state_d;
    logic            vs_q1, vs_q2, vs_fall_q;
    logic [CNTW-1:0] frame_q, frame_d;
    logic [CNTW-1:0] dump_cnt_q, dump_cnt_d, dump_cnt_inc;
    logic            dump_en_q, dump_en_d;
    logic            finish_q, finish_d;

    // Sync samples reset high so the first low sample after reset is a real fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q1     <= 1'b1;
            vs_q2     <= 1'b1;
            vs_fall_q <= 1'b0;
        end else begin
            vs_q1     <= VGA_VS;
            vs_q2     <= vs_q1;
            vs_fall_q <= vs_q2 & ~vs_q1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q    <= '0;
            dump_cnt_q <= '0;
            dump_en_q  <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            frame_q    <= frame_d;
            dump_cnt_q <= dump_cnt_d;
            dump_en_q  <= dump_en_d;
            finish_q   <= finish_d;
        end
    end

    // Next-state logic; decisions use the pre-increment frame count.
    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        dump_cnt_d   = dump_cnt_q;
        finish_d     = finish_q;
        dump_cnt_inc = dump_cnt_q + CNTW'(1);

        if (downloading) begin
            // Download overrides any pending frame edge.
            state_d    = ST_IDLE;
            frame_d    = '0;
            dump_cnt_d = '0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_ARMED;
        end else if (vs_fall_q) begin
            frame_d = frame_q + CNTW'(1);
            if (FINISH_FRAME != 0 && frame_q == FINISH_C) begin
                finish_d = 1'b1;
            end
            case (state_q)
                ST_ARMED: begin
                    if (frame_q == START_C) begin
                        state_d    = ST_DUMPING;
                        dump_cnt_d = '0;
                    end
                end
                ST_DUMPING: begin
                    dump_cnt_d = dump_cnt_inc;
                    if (DUMP_FRAMES != 0 && dump_cnt_inc == DUMP_C) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end

        dump_en_d = (state_d == ST_DUMPING);
    end

    assign frame_cnt  = frame_q;
    assign vs_fall    = vs_fall_q;
    assign dump_en    = dump_en_q;
    assign finish_req = finish_q;
    assign trig_st    = state_q;

endmodule
